// File: rtl/instruction_fetch_unit_pkg.sv
// Shared encodings for the fetch stage: next-PC select, fetch FSM states and the IF/ID register layout.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    PC_SRC_SEQ = 2'd0,
    PC_SRC_BR  = 2'd1,
    PC_SRC_J   = 2'd2,
    PC_SRC_JR  = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/instruction_fetch_unit_next_pc_calc.sv
// Combinational next-PC targets (seq/branch/jump/jr) and the pc_src mux; no state, no backpressure.
module instruction_fetch_unit_next_pc_calc
  import instruction_fetch_unit_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_pc_src,
  input  logic [31:0] i_id_pc_plus4,
  input  logic [15:0] i_id_imm16,
  input  logic [25:0] i_id_target26,
  input  logic [31:0] i_jr_addr,
  output logic [31:0] o_seq_pc,
  output logic [31:0] o_target_pc,
  output logic        o_redirect,
  output logic        o_jr_misaligned
);

  logic [31:0] w_br_pc;
  logic [31:0] w_j_pc;

  assign o_seq_pc = i_pc + 32'd4;
  // Branch offset is in words, so sign-extend then scale by 4.
  assign w_br_pc  = i_id_pc_plus4 + {{14{i_id_imm16[15]}}, i_id_imm16, 2'b00};
  assign w_j_pc   = {i_id_pc_plus4[31:28], i_id_target26, 2'b00};

  always_comb begin
    o_target_pc = o_seq_pc;
    case (pc_src_e'(i_pc_src))
      PC_SRC_BR: o_target_pc = w_br_pc;
      PC_SRC_J:  o_target_pc = w_j_pc;
      PC_SRC_JR: o_target_pc = i_jr_addr;
      default:   o_target_pc = o_seq_pc;
    endcase
  end

  assign o_redirect      = (i_pc_src != PC_SRC_SEQ);
  assign o_jr_misaligned = (i_pc_src == PC_SRC_JR) && (i_jr_addr[1:0] != 2'b00);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns pc (imem_addr is combinational from it) and loads IF/ID one edge after the PC is presented.
// Redirect beats flush beats stall; stall holds pc and IF/ID; any fault freezes the stage until reset.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [1:0]  i_pc_src,
  input  logic [31:0] i_id_pc_plus4,
  input  logic [15:0] i_id_imm16,
  input  logic [25:0] i_id_target26,
  input  logic [31:0] i_jr_addr,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_instr,
  output logic [31:0] o_if_id_instr,
  output logic [31:0] o_if_id_pc4,
  output logic        o_if_id_valid,
  output logic        o_fetch_fault
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  if_id_t       r_if_id;
  if_id_t       w_if_id_nxt;
  logic         r_fault;
  logic         w_fault_nxt;
  logic         w_pc_loaded;

  logic [31:0]  w_seq_pc;
  logic [31:0]  w_target_pc;
  logic         w_redirect;
  logic         w_jr_misaligned;

  instruction_fetch_unit_next_pc_calc u_next_pc_calc (
    .i_pc            (r_pc),
    .i_pc_src        (i_pc_src),
    .i_id_pc_plus4   (i_id_pc_plus4),
    .i_id_imm16      (i_id_imm16),
    .i_id_target26   (i_id_target26),
    .i_jr_addr       (i_jr_addr),
    .o_seq_pc        (w_seq_pc),
    .o_target_pc     (w_target_pc),
    .o_redirect      (w_redirect),
    .o_jr_misaligned (w_jr_misaligned)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_if_id_nxt = r_if_id;
    w_fault_nxt = r_fault;
    w_pc_loaded = 1'b0;
    case (r_state)
      BOOT: begin
        w_if_id_nxt = IF_ID_BUBBLE;
        w_state_nxt = RUN;
      end
      RUN: begin
        if (w_redirect) begin
          // A misaligned jr never reaches pc; the old value stays for debug.
          w_if_id_nxt = IF_ID_BUBBLE;
          if (w_jr_misaligned) begin
            w_fault_nxt = 1'b1;
          end else begin
            w_pc_nxt    = w_target_pc;
            w_pc_loaded = 1'b1;
          end
        end else if (i_flush) begin
          w_if_id_nxt = IF_ID_BUBBLE;
          w_pc_nxt    = w_seq_pc;
          w_pc_loaded = 1'b1;
        end else if (!i_stall) begin
          w_if_id_nxt = '{instr: i_imem_instr, pc4: w_seq_pc, valid: 1'b1};
          w_pc_nxt    = w_seq_pc;
          w_pc_loaded = 1'b1;
        end
        if (w_pc_loaded && (w_pc_nxt[31:2] >= 30'(IMEM_WORDS))) begin
          w_fault_nxt = 1'b1;
        end
        if (w_fault_nxt) begin
          w_state_nxt = HALT;
        end
      end
      HALT: begin
        w_if_id_nxt = IF_ID_BUBBLE;
      end
      default: begin
        w_if_id_nxt = IF_ID_BUBBLE;
        w_state_nxt = HALT;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_if_id <= IF_ID_BUBBLE;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_if_id <= w_if_id_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  assign o_imem_addr   = r_pc;
  assign o_if_id_instr = r_if_id.instr;
  assign o_if_id_pc4   = r_if_id.pc4;
  assign o_if_id_valid = r_if_id.valid;
  assign o_fetch_fault = r_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a randomized run against a behavioural fetch model.
module tb_instruction_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_stall;
  logic        i_flush;
  logic [1:0]  i_pc_src;
  logic [31:0] i_id_pc_plus4;
  logic [15:0] i_id_imm16;
  logic [25:0] i_id_target26;
  logic [31:0] i_jr_addr;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_instr;
  logic [31:0] o_if_id_instr;
  logic [31:0] o_if_id_pc4;
  logic        o_if_id_valid;
  logic        o_fetch_fault;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mem [0:255];

  // Behavioural model of the stage as seen from outside.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_fault, m_boot;

  instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(256)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .i_pc_src      (i_pc_src),
    .i_id_pc_plus4 (i_id_pc_plus4),
    .i_id_imm16    (i_id_imm16),
    .i_id_target26 (i_id_target26),
    .i_jr_addr     (i_jr_addr),
    .o_imem_addr   (o_imem_addr),
    .i_imem_instr  (i_imem_instr),
    .o_if_id_instr (o_if_id_instr),
    .o_if_id_pc4   (o_if_id_pc4),
    .o_if_id_valid (o_if_id_valid),
    .o_fetch_fault (o_fetch_fault)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if ((a >> 2) < 256) return mem[a[9:2]];
    return 32'hDEAD_BEEF;
  endfunction

  assign i_imem_instr = mem_word(o_imem_addr);

  function automatic logic [97:0] dut_vec();
    return {o_imem_addr, o_if_id_instr, o_if_id_pc4, o_if_id_valid, o_fetch_fault};
  endfunction

  function automatic logic [97:0] model_vec();
    return {m_pc, m_instr, m_pc4, m_valid, m_fault};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
    m_valid = 1'b0; m_fault = 1'b0; m_boot = 1'b1;
  endtask

  task automatic clear_inputs();
    i_stall = 0; i_flush = 0; i_pc_src = 0; i_id_pc_plus4 = 0;
    i_id_imm16 = 0; i_id_target26 = 0; i_jr_addr = 0;
  endtask

  // One rising edge of the model, from the architectural rules.
  task automatic model_edge();
    logic [31:0] seq, tgt;
    int off;
    seq = m_pc + 32'd4;
    off = $signed(i_id_imm16);
    case (i_pc_src)
      2'd1:    tgt = i_id_pc_plus4 + 32'(off * 4);
      2'd2:    tgt = (i_id_pc_plus4 & 32'hF000_0000) | (32'(i_id_target26) * 32'd4);
      2'd3:    tgt = i_jr_addr;
      default: tgt = seq;
    endcase
    if (m_boot) begin
      m_boot = 1'b0;
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (m_fault) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (i_pc_src != 2'd0) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
      if (i_pc_src == 2'd3 && (i_jr_addr % 4) != 0) m_fault = 1'b1;
      else begin
        m_pc = tgt;
        if ((tgt >> 2) >= 256) m_fault = 1'b1;
      end
    end else if (i_flush) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0;
      m_pc = seq;
      if ((seq >> 2) >= 256) m_fault = 1'b1;
    end else if (!i_stall) begin
      m_instr = mem_word(m_pc); m_pc4 = seq; m_valid = 1'b1;
      m_pc = seq;
      if ((seq >> 2) >= 256) m_fault = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    i_reset = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge i_clk);
    #1;
    n_cmp++;
    if (o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h want=%h", o_imem_addr, 32'h0); end
    n_cmp++;
    if (o_if_id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h want=%h", o_if_id_instr, 32'h0); end
    n_cmp++;
    if (o_if_id_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got=%h want=%h", o_if_id_pc4, 32'h0); end
    n_cmp++;
    if ({o_if_id_valid, o_fetch_fault} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b%b want=00", o_if_id_valid, o_fetch_fault); end
    @(negedge i_clk);
    i_reset = 1'b0;
    model_reset();
  endtask

  task automatic test_boot();
    #1;
    n_cmp++;
    if (o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL boot_addr0 got=%h want=%h", o_imem_addr, 32'h0); end
    tick();
    n_cmp++;
    if ({o_imem_addr, o_if_id_valid} !== {32'h0, 1'b0}) begin n_fail++; $display("FAIL boot_first_run got addr=%h v=%b want addr=0 v=0", o_imem_addr, o_if_id_valid); end
    tick();
    n_cmp++;
    if ({o_imem_addr, o_if_id_valid, o_if_id_pc4, o_if_id_instr} !== {32'h4, 1'b1, 32'h4, mem[0]}) begin
      n_fail++; $display("FAIL boot_first_valid got addr=%h v=%b pc4=%h instr=%h want addr=4 v=1 pc4=4 instr=%h", o_imem_addr, o_if_id_valid, o_if_id_pc4, o_if_id_instr, mem[0]);
    end
    tick();
    n_cmp++;
    if (o_imem_addr !== 32'h8) begin n_fail++; $display("FAIL boot_addr8 got=%h want=%h", o_imem_addr, 32'h8); end
    n_cmp++;
    if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL boot_model got=%h want=%h", dut_vec(), model_vec()); end
  endtask

  task automatic test_jal();
    i_pc_src = 2'd2; i_id_target26 = 26'd3; i_id_pc_plus4 = 32'h8;
    tick();
    n_cmp++;
    if ({o_imem_addr, o_if_id_valid} !== {32'h0000_000C, 1'b0}) begin n_fail++; $display("FAIL jal got addr=%h v=%b want addr=0000000c v=0", o_imem_addr, o_if_id_valid); end
    n_cmp++;
    if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL jal_model got=%h want=%h", dut_vec(), model_vec()); end
    clear_inputs();
  endtask

  task automatic test_branch_loop();
    i_pc_src = 2'd1; i_id_pc_plus4 = 32'h0C; i_id_imm16 = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({o_imem_addr, o_if_id_valid} !== {32'h8, 1'b0}) begin n_fail++; $display("FAIL branch_loop[%0d] got addr=%h v=%b want addr=8 v=0", k, o_imem_addr, o_if_id_valid); end
    end
    clear_inputs();
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL branch_exit_model[%0d] got=%h want=%h", k, dut_vec(), model_vec()); end
    end
  endtask

  task automatic test_stall();
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({o_imem_addr, o_if_id_instr, o_if_id_pc4, o_if_id_valid} !== {32'h10, mem[3], 32'h10, 1'b1}) begin
        n_fail++; $display("FAIL stall_hold[%0d] got addr=%h instr=%h pc4=%h v=%b want addr=10 instr=%h pc4=10 v=1", k, o_imem_addr, o_if_id_instr, o_if_id_pc4, o_if_id_valid, mem[3]);
      end
    end
    i_stall = 1'b0;
    tick();
    n_cmp++;
    if ({o_imem_addr, o_if_id_instr, o_if_id_pc4} !== {32'h14, mem[4], 32'h14}) begin
      n_fail++; $display("FAIL stall_resume got addr=%h instr=%h pc4=%h want addr=14 instr=%h pc4=14", o_imem_addr, o_if_id_instr, o_if_id_pc4, mem[4]);
    end
    i_stall = 1'b1; i_pc_src = 2'd3; i_jr_addr = 32'h2C;
    tick();
    n_cmp++;
    if ({o_imem_addr, o_if_id_valid, o_if_id_instr} !== {32'h2C, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL stall_vs_jr got addr=%h v=%b instr=%h want addr=2c v=0 instr=0", o_imem_addr, o_if_id_valid, o_if_id_instr);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    int r, pw, tw, d;
    for (int k = 0; k < 400; k++) begin
      clear_inputs();
      i_stall = ($urandom_range(0, 4) == 0);
      i_flush = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 9);
      pw = $urandom_range(1, 256);
      tw = $urandom_range(0, 255);
      i_id_pc_plus4 = 32'(pw) * 32'd4;
      if (r == 7) begin
        d = tw - pw;
        i_pc_src = 2'd1; i_id_imm16 = d[15:0];
      end else if (r == 8) begin
        i_pc_src = 2'd2; i_id_target26 = 26'(tw);
      end else if (r == 9) begin
        i_pc_src = 2'd3; i_jr_addr = 32'(tw) * 32'd4;
      end
      tick();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL random[%0d] got=%h want=%h", k, dut_vec(), model_vec()); end
    end
    clear_inputs();
  endtask

  task automatic test_fault();
    apply_reset();
    tick();
    tick();
    i_pc_src = 2'd3; i_jr_addr = 32'h0000_002E;
    tick();
    n_cmp++;
    if ({o_fetch_fault, o_imem_addr, o_if_id_valid} !== {1'b1, 32'h4, 1'b0}) begin
      n_fail++; $display("FAIL jr_misaligned got f=%b addr=%h v=%b want f=1 addr=4 v=0", o_fetch_fault, o_imem_addr, o_if_id_valid);
    end
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      i_stall = $urandom_range(0, 1);
      tick();
      n_cmp++;
      if ({o_fetch_fault, o_imem_addr, o_if_id_valid} !== {1'b1, 32'h4, 1'b0}) begin
        n_fail++; $display("FAIL halt_hold[%0d] got f=%b addr=%h v=%b want f=1 addr=4 v=0", k, o_fetch_fault, o_imem_addr, o_if_id_valid);
      end
    end
    apply_reset();
    #1;
    n_cmp++;
    if (o_fetch_fault !== 1'b0) begin n_fail++; $display("FAIL fault_cleared got=%b want=0", o_fetch_fault); end
    tick();
    i_pc_src = 2'd2; i_id_pc_plus4 = 32'h0; i_id_target26 = 26'd256;
    tick();
    n_cmp++;
    if ({o_imem_addr, o_fetch_fault} !== {32'h400, 1'b1}) begin n_fail++; $display("FAIL range_fault got addr=%h f=%b want addr=400 f=1", o_imem_addr, o_fetch_fault); end
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL range_halt_model[%0d] got=%h want=%h", k, dut_vec(), model_vec()); end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    tick();
    i_pc_src = 2'd2; i_id_pc_plus4 = 32'h0; i_id_target26 = 26'd8;
    tick();
    clear_inputs();
    tick();
    n_cmp++;
    if ({o_imem_addr, o_if_id_valid, o_if_id_instr} !== {32'h24, 1'b1, mem[8]}) begin
      n_fail++; $display("FAIL pre_reset got addr=%h v=%b instr=%h want addr=24 v=1 instr=%h", o_imem_addr, o_if_id_valid, o_if_id_instr, mem[8]);
    end
    #2;
    i_reset = 1'b1;
    #1;
    n_cmp++;
    if (dut_vec() !== 98'h0) begin n_fail++; $display("FAIL async_reset got=%h want=0", dut_vec()); end
    model_reset();
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = $urandom | 32'h1;
    i_reset = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_boot();
    test_jal();
    test_branch_loop();
    test_stall();
    test_random();
    test_fault();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
